// File: rtl/random_delay.sv
// Random start delay for the reaction timer: a free-running 7-bit LFSR picks
// a millisecond count that is timed out after the sequencer requests a delay.
module random_delay #(
  parameter int CLK_PER_MS   = 50000,
  parameter int MIN_DELAY_MS = 250,
  parameter int STEP_MS      = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_lfsr,
  input  logic       start_delay,
  output logic       time_out,
  output logic       delay_active,
  output logic [6:0] lfsr_q
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [15:0] PRESC_LAST = 16'(CLK_PER_MS - 1);
  localparam logic [15:0] MIN_W      = 16'(MIN_DELAY_MS);
  localparam logic [15:0] STEP_W     = 16'(STEP_MS);

  state_t      state, state_next;
  logic [15:0] prescaler;
  logic [15:0] ms_cnt;
  logic [15:0] load_ms;
  logic        start_d;
  logic        rise;
  logic        ms_tick;
  logic        last_ms;

  assign rise    = start_delay & ~start_d;
  assign ms_tick = (prescaler == PRESC_LAST);
  assign last_ms = (ms_cnt == 16'd1);
  assign load_ms = MIN_W + ({9'd0, lfsr_q} * STEP_W);

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rise) state_next = COUNT;
      // Dropping the request beats the terminal millisecond.
      COUNT: begin
        if (!start_delay)          state_next = IDLE;
        else if (ms_tick && last_ms) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst)                 lfsr_q <= 7'h01;
    else if (lfsr_q == 7'h0) lfsr_q <= 7'h01;
    else if (en_lfsr)        lfsr_q <= {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
  end

  always_ff @(posedge clk) begin
    if (rst) start_d <= 1'b0;
    else     start_d <= start_delay;
  end

  // Load uses the LFSR value present before this edge's shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
      ms_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            ms_cnt    <= load_ms;
            prescaler <= '0;
          end
        end
        COUNT: begin
          if (ms_tick) begin
            prescaler <= '0;
            if (!last_ms) ms_cnt <= ms_cnt - 16'd1;
          end else begin
            prescaler <= prescaler + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign time_out     = (state == DONE);
  assign delay_active = (state == COUNT);

endmodule

// File: tb/tb_random_delay.sv
// Self-checking bench for random_delay: a small build (4 clk/ms, 2 ms floor,
// 1 ms step) plus a 1 clk/ms build with the default floor and step.
module tb_random_delay;

  localparam int C        = 4;
  localparam int MN       = 2;
  localparam int ST       = 1;
  localparam int DEF_MIN  = 250;
  localparam int DEF_STEP = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en_lfsr = 1'b0;
  logic       start_delay = 1'b0;
  logic       en_b = 1'b0;
  logic       start_b = 1'b0;
  logic       time_out, delay_active;
  logic [6:0] lfsr_q;
  logic       time_out_b, delay_active_b;
  logic [6:0] lfsr_b;

  int checks = 0;
  int errors = 0;

  // Maximal-length sequence of x^7+x^6+1 starting from 01, indexed by step count.
  logic [6:0] seq [127];
  int idx_a = 0;
  int idx_b = 0;

  random_delay #(.CLK_PER_MS(C), .MIN_DELAY_MS(MN), .STEP_MS(ST)) dut (
    .clk(clk), .rst(rst), .en_lfsr(en_lfsr), .start_delay(start_delay),
    .time_out(time_out), .delay_active(delay_active), .lfsr_q(lfsr_q)
  );

  random_delay #(.CLK_PER_MS(1)) dut_b (
    .clk(clk), .rst(rst), .en_lfsr(en_b), .start_delay(start_b),
    .time_out(time_out_b), .delay_active(delay_active_b), .lfsr_q(lfsr_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge; the model steps with the inputs that edge samples.
  task automatic tick();
    if (rst) begin
      idx_a = 0;
      idx_b = 0;
    end else begin
      if (en_lfsr) idx_a = (idx_a + 1) % 127;
      if (en_b)    idx_b = (idx_b + 1) % 127;
    end
    @(posedge clk);
    #1;
  endtask

  // Edges after the sampling edge until time_out shows; counts cycles not in COUNT meanwhile.
  task automatic run_count(input bit rand_en, input int budget, output int n, output int gaps);
    n = 0;
    gaps = 0;
    while (n < budget) begin
      if (rand_en) en_lfsr = 1'($urandom_range(0, 1));
      tick();
      n++;
      if (time_out) break;
      if (delay_active !== 1'b1) gaps++;
    end
    en_lfsr = 1'b0;
  endtask

  initial begin
    int n, gaps, exp_d, pulses, zeros, mism, k;
    logic [6:0] v;

    v = 7'h01;
    for (int i = 0; i < 127; i++) begin
      seq[i] = v;
      v = {v[5:0], v[6] ^ v[5]};
    end

    // Reset state
    rst = 1'b1;
    tick();
    check("rst_lfsr", lfsr_q, 7'h01);
    check("rst_time_out", time_out, 1'b0);
    check("rst_active", delay_active, 1'b0);
    check("rst_lfsr_b", lfsr_b, 7'h01);
    rst = 1'b0;

    // Three advances then hold
    en_lfsr = 1'b1;
    tick(); check("lfsr_step1", lfsr_q, 7'h02);
    tick(); check("lfsr_step2", lfsr_q, 7'h04);
    tick(); check("lfsr_step3", lfsr_q, 7'h08);
    en_lfsr = 1'b0;
    tick(); check("lfsr_hold", lfsr_q, 7'h08);

    // Delay from 08: 10 ms = 40 edges
    exp_d = MN + int'(seq[idx_a]) * ST;
    check("delay_from_08", exp_d, 10);
    start_delay = 1'b1;
    tick();
    check("active_after_rise", delay_active, 1'b1);
    run_count(1'b0, exp_d * C + 50, n, gaps);
    check("latency_08", n, exp_d * C);
    check("active_gaps_08", gaps, 0);
    check("active_in_done", delay_active, 1'b0);
    tick();
    check("pulse_width", time_out, 1'b0);
    check("idle_after_done", delay_active, 1'b0);
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (time_out || delay_active) pulses++;
    end
    check("no_retrigger", pulses, 0);
    start_delay = 1'b0;
    tick();

    // Full period from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    en_lfsr = 1'b1;
    zeros = 0;
    mism = 0;
    for (int i = 0; i < 127; i++) begin
      tick();
      if (lfsr_q == 7'h00) zeros++;
      if (lfsr_q !== seq[idx_a]) mism++;
    end
    check("period_no_zero", zeros, 0);
    check("period_track", mism, 0);
    check("period_return", lfsr_q, 7'h01);
    for (int i = 0; i < 5; i++) tick();
    check("lfsr_to_20", lfsr_q, 7'h20);
    tick();
    check("lfsr_to_41", lfsr_q, 7'h41);
    en_lfsr = 1'b0;

    // Randomised delays with the LFSR moving during the count
    for (int it = 0; it < 6; it++) begin
      en_lfsr = 1'b1;
      k = int'($urandom_range(0, 40));
      for (int i = 0; i < k; i++) tick();
      exp_d = MN + int'(seq[idx_a]) * ST;
      en_lfsr = 1'($urandom_range(0, 1));
      start_delay = 1'b1;
      tick();
      check("rand_active", delay_active, 1'b1);
      run_count(1'b1, exp_d * C + 50, n, gaps);
      check("rand_latency", n, exp_d * C);
      check("rand_gaps", gaps, 0);
      check("rand_lfsr", lfsr_q, seq[idx_a]);
      tick();
      start_delay = 1'b0;
      tick();
    end

    // Abort mid-count, then a fresh rise runs the full count
    exp_d = MN + int'(seq[idx_a]) * ST;
    start_delay = 1'b1;
    tick();
    for (int i = 0; i < 15; i++) tick();
    start_delay = 1'b0;
    tick();
    check("abort_inactive", delay_active, 1'b0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (time_out) pulses++;
    end
    check("abort_no_pulse", pulses, 0);
    start_delay = 1'b1;
    tick();
    run_count(1'b0, exp_d * C + 50, n, gaps);
    check("restart_latency", n, exp_d * C);
    tick();
    start_delay = 1'b0;
    tick();

    // Reset mid-count wins
    en_lfsr = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    en_lfsr = 1'b0;
    start_delay = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    check("midrst_active", delay_active, 1'b0);
    check("midrst_time_out", time_out, 1'b0);
    check("midrst_lfsr", lfsr_q, 7'h01);
    rst = 1'b0;
    start_delay = 1'b0;
    tick();
    check("midrst_idle", delay_active, 1'b0);
    exp_d = MN + int'(seq[idx_a]) * ST;
    start_delay = 1'b1;
    tick();
    check("post_rst_active", delay_active, 1'b1);
    run_count(1'b0, exp_d * C + 50, n, gaps);
    check("post_rst_latency", n, 12);
    tick();
    start_delay = 1'b0;
    tick();

    // Default floor/step at 1 clk/ms from lfsr 7F: 2790 edges
    en_b = 1'b1;
    k = 0;
    while (seq[idx_b] != 7'h7F && k < 130) begin
      tick();
      k++;
    end
    en_b = 1'b0;
    check("b_lfsr_7f", lfsr_b, 7'h7F);
    exp_d = DEF_MIN + int'(seq[idx_b]) * DEF_STEP;
    start_b = 1'b1;
    tick();
    check("b_active", delay_active_b, 1'b1);
    n = 0;
    gaps = 0;
    while (n < 3000) begin
      tick();
      n++;
      if (time_out_b) break;
      if (delay_active_b !== 1'b1) gaps++;
    end
    check("b_latency", n, 2790);
    check("b_model_latency", n, exp_d);
    check("b_gaps", gaps, 0);
    tick();
    check("b_pulse_width", time_out_b, 1'b0);
    start_b = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/random_delay.md
Name: random_delay

Overview:
- Downstream partner of the start-lights sequencer in the reaction-timer datapath.
- Runs a free-running 7-bit LFSR while the sequencer enables it (lights idle), which seeds an unpredictable value.
- When the sequencer requests a delay (all lights lit), the block converts the captured LFSR value into a millisecond count and times it out.
- Then pulses time_out so the sequencer clears the lights and reaction timing starts.

Parameters:
- CLK_PER_MS, 50000, clk cycles per millisecond (50 MHz board clock); legal range 1..65536.
- MIN_DELAY_MS, 250, fixed delay floor in ms.
- STEP_MS, 20, ms added per LFSR count. Constraint: MIN_DELAY_MS + 127*STEP_MS <= 65535 and >= 1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- en_lfsr  input  1  from sequencer; 1 = advance LFSR this cycle.
- start_delay  input  1  from sequencer; level, high while it waits in its delay state.
- time_out  output  1  to sequencer; one-cycle pulse when the delay expires.
- delay_active  output  1  1 while the block is counting (state COUNT).
- lfsr_q  output  7  current LFSR value, for debug/display.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; lfsr_q=7'h01; prescaler=0; ms_cnt=0; start_d (previous start_delay)=0; time_out=0; delay_active=0. Reset wins over every other condition, including mid-COUNT.
- LFSR: Fibonacci, polynomial x^7+x^6+1.
  - When en_lfsr=1: lfsr_q <= {lfsr_q[5:0], lfsr_q[6]^lfsr_q[5]}.
  - Holds when en_lfsr=0. Advances in any state.
  - Period 127 and never 0. If lfsr_q is ever 0 (lock-up guard), the next edge loads 7'h01 regardless of en_lfsr.
- Start detect: start_d <= start_delay every cycle. Rise = start_delay & ~start_d.
- Moore FSM, 3 states:
  - IDLE: on rise, go to COUNT. Same edge: ms_cnt <= MIN_DELAY_MS + lfsr_q*STEP_MS (16-bit, using lfsr_q before any update at that edge); prescaler <= 0. Otherwise stay.
  - COUNT: each edge prescaler increments.
    - At prescaler==CLK_PER_MS-1, prescaler wraps to 0. If ms_cnt==1, go DONE; else ms_cnt decrements.
    - If start_delay==0 at any edge in COUNT, abort to IDLE. No time_out; abort has priority over the terminal check.
  - DONE: time_out=1 for exactly this one cycle; next edge unconditionally goes to IDLE.
- Outputs decoded from registered state only: time_out=(state==DONE), delay_active=(state==COUNT).
- Latency: with delay D ms, state enters DONE exactly D*CLK_PER_MS edges after the edge that sampled rise. time_out is high for the cycle that follows.
- start_delay still high after DONE does not retrigger; a new rise (low then high) is required.
- A rise while in COUNT or DONE is ignored.
- Arithmetic: product and sum computed at 16 bits, no truncation given the constraint. ms_cnt never loads 0.

Test Plan (CLK_PER_MS=4, MIN_DELAY_MS=2, STEP_MS=1 unless noted):
- Reset, then en_lfsr=1 for 3 cycles, then 0 -> lfsr_q sequence 01,02,04,08, holds 08.
- From 08: raise start_delay and hold -> delay_active=1 from next cycle; time_out single pulse exactly 40 edges (D=10 ms) after the sampling edge; state returns to IDLE; no second pulse while start_delay stays high.
- Run en_lfsr=1 for 127 cycles from reset -> lfsr_q returns to 01, never 00 in between. Also advance 6 times from 01 -> 20 then 41.
- Mid-COUNT, drop start_delay after 15 cycles -> delay_active=0 next cycle, time_out never asserts; a fresh rise restarts with a full count.
- Assert rst for one cycle mid-COUNT -> next cycle all outputs 0, lfsr_q=01, IDLE; a subsequent rise works normally.
- Defaults (CLK_PER_MS=50000, MIN=250, STEP=20), lfsr_q=7F -> ms_cnt loads 2790, time_out at 139,500,000 edges; a CLK_PER_MS=1 build gives time_out after exactly D edges.
